canny_pixel_packer: RTL and testbench
=====================================

# canny_pixel_packer

Parametrised packer between the Canny edge pipeline and the frame-buffer BRAM write port. It takes one pixel per `pix_de` strobe and keeps the top `PIXEL_BITS` bits of each pixel. It packs `DATA_WIDTH/PIXEL_BITS` pixels per memory word and issues one write per full word with no bubble cycle. A frame ends either when `TOTAL_PIXELS` pixels arrive, which zero-pads and flushes a partial last word and pulses `frame_tick`, or when `frame_start` arrives early, which discards the partial word and pulses `frame_err`.

## Interface
Parameters:
- `IN_WIDTH`, 8: width of incoming pixel sample.
- `DATA_WIDTH`, 8: memory word width.
- `PIXEL_BITS`, 1: stored bits per pixel.
  - Legal values: 1, 2, 4, 8.
  - Must divide `DATA_WIDTH` and be ≤ `IN_WIDTH`.
- `TOTAL_PIXELS`, 42240: pixels per frame.
- `MSB_FIRST`, 0:
  - 0: slot k occupies `wData[k*PIXEL_BITS +: PIXEL_BITS]`.
  - 1: slot k occupies `wData[DATA_WIDTH-1-k*PIXEL_BITS -: PIXEL_BITS]`.
- Derived:
  - `PIX_PER_WORD = DATA_WIDTH/PIXEL_BITS`.
  - `TOTAL_WORDS = ceil(TOTAL_PIXELS/PIX_PER_WORD)`.
  - `ADDR_WIDTH = max(1, $clog2(TOTAL_WORDS))`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `frame_start`  in  1  one-cycle pulse marking the start of a frame.
- `pix_de`  in  1  pixel valid strobe.
- `pix_data`  in  `IN_WIDTH`  pixel sample; `pix_data[IN_WIDTH-1 -: PIXEL_BITS]` is stored.
- `we`  out  1  registered write enable, one cycle per word.
- `wData`  out  `DATA_WIDTH`  packed word, valid when `we`=1.
- `wAddr`  out  `ADDR_WIDTH`  word address, valid when `we`=1.
- `frame_tick`  out  1  one-cycle pulse on frame completion.
- `frame_err`  out  1  one-cycle pulse on an aborted (short) frame.

## Operation
- State machine has two states, `ST_WAIT` and `ST_RUN`.
- Reset:
  - State goes to `ST_WAIT`.
  - All outputs, the assembly register, slot counter, pixel counter and word address are cleared to 0.
- `ST_WAIT`:
  - `pix_de` is ignored.
  - `frame_start` moves the block to `ST_RUN` with all counters cleared.
  - If `pix_de` is high in the same cycle as `frame_start`, that pixel is accepted as pixel 0.
- `ST_RUN`, on `pix_de`=1:
  - The pixel is written into the current slot of the assembly register.
  - The slot counter and pixel counter each increment by 1.
  - `pix_de`=0 holds all state; gaps of any length are legal.
- Word emit happens when the accepted pixel fills slot `PIX_PER_WORD-1`:
  - Next cycle: `we`=1, `wData` = the assembled word including the current pixel, `wAddr` = current word index.
  - The word index then increments and the assembly register and slot counter clear.
  - A pixel arriving in the very next cycle goes into slot 0 of the next word; throughput is 1 pixel/cycle sustained.
- Frame end happens when the accepted pixel is pixel `TOTAL_PIXELS-1`:
  - The word is emitted even if partial; unfilled slots are 0.
  - `frame_tick`=1 in the same cycle as that final `we`.
  - All counters clear and the state returns to `ST_WAIT`.
  - `pix_de` in the following cycles is ignored until the next `frame_start`.
- Early `frame_start` in `ST_RUN` (pixel counter ≠ 0):
  - The partial word is discarded; no `we` is issued for it.
  - `frame_err`=1 next cycle.
  - Counters clear, state stays in `ST_RUN`, and a coincident `pix_de` is accepted as pixel 0.
- `frame_start` in `ST_RUN` with pixel counter = 0 is a restart with no error.
- If a word completes in the same cycle as an early `frame_start`, that word is emitted: `we` and `frame_err` are both 1 the next cycle.
- If the final pixel coincides with `frame_start`:
  - The frame completes normally with `frame_tick` and no error.
  - The new frame starts (state `ST_RUN`) and the coincident pixel is counted as the final pixel of the old frame only.
- Arithmetic:
  - The pixel counter is `$clog2(TOTAL_PIXELS)` bits; the slot counter is `max(1,$clog2(PIX_PER_WORD))` bits.
  - `wAddr` never exceeds `TOTAL_WORDS-1` and wraps to 0 only via frame end or restart.
- `PIXEL_BITS` = `DATA_WIDTH` degenerates to one write per pixel.

## Timing
- All outputs are registered.
- `we`, `frame_tick` and `frame_err` are 1-cycle pulses and default to 0.
- Latency is 1 cycle from the completing `pix_de` to `we`.
- Latency is 1 cycle from an early `frame_start` to `frame_err`.
- `wData` and `wAddr` hold their last values when `we`=0.
- Reset mid-frame: outputs are 0 the next cycle, the partial word is lost, and no `frame_err` is raised.

## Test plan
- Parameters `PIXEL_BITS`=1, `TOTAL_PIXELS`=20, `MSB_FIRST`=0. Stimulus: `frame_start`, then 20 back-to-back pixels; pixel k uses 0xFF if k is even, else 0x00.
  - Required: `we` at addr 0, 1, 2 with data 0x55, 0x55, 0x05.
  - Required: `frame_tick` coincides with the addr-2 write; there are no gaps between writes.
- Same stream with `MSB_FIRST`=1 → data 0xAA, 0xAA, 0xA0.
- `PIXEL_BITS`=4, `TOTAL_PIXELS`=4. Stimulus: pixels 0x1F, 0xE0, 0x70, 0x80 with random `pix_de` gaps.
  - Required: words 0xE1 at addr 0 and 0x87 at addr 1; `frame_tick` with the second write.
- Early abort with `PIXEL_BITS`=1, `TOTAL_PIXELS`=20: after 11 pixels, `frame_start` with coincident `pix_de`.
  - Required: one write (addr 0) only, `frame_err` pulse, and the next word is written to addr 0 again.
  - Required: the full following frame produces the normal 3 writes and `frame_tick`.
- Pixels in `ST_WAIT` (before `frame_start` and after `frame_tick`) → no `we`, no counter change.
- Assert `reset` after 5 pixels → all outputs 0 next cycle and no `frame_err`; a fresh frame is written from addr 0.

Source files
------------

// File: rtl/canny_pixel_packer.sv
// Packs thresholded Canny pixels into memory words for the frame-buffer BRAM
// write port, signalling frame completion (frame_tick) and aborted frames (frame_err).
module canny_pixel_packer #(
    parameter int IN_WIDTH      = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int PIXEL_BITS    = 1,
    parameter int TOTAL_PIXELS  = 42240,
    parameter int MSB_FIRST     = 0,
    localparam int PIX_PER_WORD = DATA_WIDTH / PIXEL_BITS,
    localparam int TOTAL_WORDS  = (TOTAL_PIXELS + PIX_PER_WORD - 1) / PIX_PER_WORD,
    localparam int ADDR_WIDTH   = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  pix_de,
    input  logic [IN_WIDTH-1:0]   pix_data,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] wData,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic                  frame_tick,
    output logic                  frame_err
);

    localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int PIX_W  = (TOTAL_PIXELS > 1) ? $clog2(TOTAL_PIXELS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PIX_PER_WORD - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(TOTAL_PIXELS - 1);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   asm_r, asm_s, base_asm_s, word_s;
    logic [SLOT_W-1:0]       slot_r, slot_s, base_slot_s;
    logic [PIX_W-1:0]        pix_cnt_r, pix_cnt_s, base_pix_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s, base_addr_s;
    logic [PIXEL_BITS-1:0]   pixel_s;
    logic                    run_s, early_s, old_done_s, zero_base_s;
    logic                    accept_s, final_s, emit_s;
    logic                    pix_unused_s;

    function automatic logic [DATA_WIDTH-1:0] place_pixel(input logic [PIXEL_BITS-1:0] px,
                                                          input logic [SLOT_W-1:0]     slot);
        int pos;
        pos = (MSB_FIRST != 0) ? (PIX_PER_WORD - 1 - int'(slot)) : int'(slot);
        return DATA_WIDTH'(px) << (pos * PIXEL_BITS);
    endfunction

    assign pixel_s      = pix_data[IN_WIDTH-1 -: PIXEL_BITS];
    assign pix_unused_s = ^pix_data;

    // A pixel that completes the running word or frame belongs to the old frame,
    // even when frame_start arrives with it; otherwise frame_start begins from empty.
    assign run_s       = (state_r == ST_RUN);
    assign early_s     = run_s && frame_start && (pix_cnt_r != '0);
    assign old_done_s  = run_s && pix_de && ((slot_r == LAST_SLOT) || (pix_cnt_r == LAST_PIX));
    assign zero_base_s = frame_start && !old_done_s;
    assign accept_s    = pix_de && (run_s || frame_start);

    assign base_asm_s  = zero_base_s ? '0 : asm_r;
    assign base_slot_s = zero_base_s ? '0 : slot_r;
    assign base_pix_s  = zero_base_s ? '0 : pix_cnt_r;
    assign base_addr_s = zero_base_s ? '0 : addr_r;

    assign word_s  = base_asm_s | place_pixel(pixel_s, base_slot_s);
    assign final_s = accept_s && (base_pix_s == LAST_PIX);
    assign emit_s  = accept_s && ((base_slot_s == LAST_SLOT) || final_s);

    // Next-state for the FSM and the assembly/slot/pixel/address counters.
    always_comb begin
        state_s   = state_r;
        asm_s     = base_asm_s;
        slot_s    = base_slot_s;
        pix_cnt_s = base_pix_s;
        addr_s    = base_addr_s;
        if (final_s || (early_s && emit_s)) begin
            asm_s     = '0;
            slot_s    = '0;
            pix_cnt_s = '0;
            addr_s    = '0;
        end else if (emit_s) begin
            asm_s     = '0;
            slot_s    = '0;
            pix_cnt_s = base_pix_s + PIX_W'(1);
            addr_s    = base_addr_s + ADDR_WIDTH'(1);
        end else if (accept_s) begin
            asm_s     = word_s;
            slot_s    = base_slot_s + SLOT_W'(1);
            pix_cnt_s = base_pix_s + PIX_W'(1);
        end else begin
            asm_s     = base_asm_s;
            slot_s    = base_slot_s;
        end
        if (frame_start) begin
            state_s = ST_RUN;
        end else if (final_s) begin
            state_s = ST_WAIT;
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_WAIT;
            asm_r      <= '0;
            slot_r     <= '0;
            pix_cnt_r  <= '0;
            addr_r     <= '0;
            we         <= 1'b0;
            wData      <= '0;
            wAddr      <= '0;
            frame_tick <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_r    <= state_s;
            asm_r      <= asm_s;
            slot_r     <= slot_s;
            pix_cnt_r  <= pix_cnt_s;
            addr_r     <= addr_s;
            we         <= emit_s;
            wData      <= emit_s ? word_s : wData;
            wAddr      <= emit_s ? base_addr_s : wAddr;
            frame_tick <= final_s;
            frame_err  <= early_s && !final_s;
        end
    end

endmodule

// File: tb/tb_canny_pixel_packer.sv
// Bench for canny_pixel_packer: table vectors, directed frame sequences and
// random traffic against a pixel-queue reference model.
module tb_canny_pixel_packer;

    localparam int PPW = 8;
    localparam int TP  = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_ab, fs_ab, de_ab;
    logic [7:0] px_ab;
    logic       we_a, tick_a, err_a, we_b, tick_b, err_b;
    logic [7:0] data_a, data_b;
    logic [1:0] addr_a, addr_b;

    logic       reset_c, fs_c, de_c;
    logic [7:0] px_c;
    logic       we_c, tick_c, err_c;
    logic [7:0] data_c;
    logic [0:0] addr_c;

    canny_pixel_packer #(.IN_WIDTH(8), .DATA_WIDTH(8), .PIXEL_BITS(1), .TOTAL_PIXELS(20), .MSB_FIRST(0)) dut_a (
        .clk(clk), .reset(reset_ab), .frame_start(fs_ab), .pix_de(de_ab), .pix_data(px_ab),
        .we(we_a), .wData(data_a), .wAddr(addr_a), .frame_tick(tick_a), .frame_err(err_a));

    canny_pixel_packer #(.IN_WIDTH(8), .DATA_WIDTH(8), .PIXEL_BITS(1), .TOTAL_PIXELS(20), .MSB_FIRST(1)) dut_b (
        .clk(clk), .reset(reset_ab), .frame_start(fs_ab), .pix_de(de_ab), .pix_data(px_ab),
        .we(we_b), .wData(data_b), .wAddr(addr_b), .frame_tick(tick_b), .frame_err(err_b));

    canny_pixel_packer #(.IN_WIDTH(8), .DATA_WIDTH(8), .PIXEL_BITS(4), .TOTAL_PIXELS(4), .MSB_FIRST(0)) dut_c (
        .clk(clk), .reset(reset_c), .frame_start(fs_c), .pix_de(de_c), .pix_data(px_c),
        .we(we_c), .wData(data_c), .wAddr(addr_c), .frame_tick(tick_c), .frame_err(err_c));

    int errors = 0;
    int checks = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: the pixels of the frame in progress, one bit each.
    bit         m_in_frame;
    bit         m_q[$];
    logic [7:0] m_da, m_db;
    logic [1:0] m_addr;
    bit         m_we, m_tick, m_err;

    function automatic logic [7:0] pack(input int start, input bit msb);
        logic [7:0] w;
        w = 8'h00;
        for (int j = start; j < m_q.size(); j++) begin
            if (m_q[j]) w[msb ? 7 - (j - start) : (j - start)] = 1'b1;
        end
        return w;
    endfunction

    task automatic model_step(input bit rst, input bit fs, input bit de, input logic [7:0] px);
        int n_old, n, w;
        bit old_done, early;
        m_we = 1'b0; m_tick = 1'b0; m_err = 1'b0;
        if (rst) begin
            m_q.delete(); m_in_frame = 1'b0; m_da = 8'h00; m_db = 8'h00; m_addr = 2'd0;
            return;
        end
        n_old    = m_q.size();
        old_done = m_in_frame && de && ((((n_old + 1) % PPW) == 0) || (n_old + 1 == TP));
        early    = m_in_frame && fs && (n_old != 0);
        if (early && !old_done) begin
            m_err = 1'b1;
            m_q.delete();
        end
        if (!m_in_frame && fs) begin
            m_in_frame = 1'b1;
            m_q.delete();
        end
        if (m_in_frame && de) begin
            m_q.push_back(px[7]);
            n = m_q.size();
            if ((n % PPW) == 0 || n == TP) begin
                w = (n - 1) / PPW;
                m_we = 1'b1; m_addr = 2'(w);
                m_da = pack(w * PPW, 1'b0);
                m_db = pack(w * PPW, 1'b1);
                if (n == TP) begin
                    m_tick = 1'b1; m_q.delete(); m_in_frame = fs;
                end else if (early) begin
                    m_err = 1'b1; m_q.delete();
                end
            end
        end
    endtask

    int   log_addr[$];
    int   err_seen, tick_seen;

    task automatic step_ab(input bit rst, input bit fs, input bit de, input logic [7:0] px);
        reset_ab = rst; fs_ab = fs; de_ab = de; px_ab = px;
        @(posedge clk); #1;
        model_step(rst, fs, de, px);
        chk("we_a",   32'(we_a),   32'(m_we));
        chk("we_b",   32'(we_b),   32'(m_we));
        chk("data_a", 32'(data_a), 32'(m_da));
        chk("data_b", 32'(data_b), 32'(m_db));
        chk("addr_a", 32'(addr_a), 32'(m_addr));
        chk("addr_b", 32'(addr_b), 32'(m_addr));
        chk("tick_a", 32'(tick_a), 32'(m_tick));
        chk("tick_b", 32'(tick_b), 32'(m_tick));
        chk("err_a",  32'(err_a),  32'(m_err));
        chk("err_b",  32'(err_b),  32'(m_err));
        if (we_a)   log_addr.push_back(int'(addr_a));
        if (err_a)  err_seen++;
        if (tick_a) tick_seen++;
    endtask

    logic [7:0] c_data[$];
    logic [0:0] c_addr[$];
    bit         c_tick_we[$];
    int         c_ticks, c_errs;

    task automatic step_c(input bit rst, input bit fs, input bit de, input logic [7:0] px);
        reset_c = rst; fs_c = fs; de_c = de; px_c = px;
        @(posedge clk); #1;
        if (we_c) begin
            c_data.push_back(data_c); c_addr.push_back(addr_c); c_tick_we.push_back(tick_c);
        end
        if (tick_c) c_ticks++;
        if (err_c)  c_errs++;
    endtask

    typedef struct {
        bit         fs;
        bit         de;
        logic [7:0] px;
        bit         e_we;
        bit         e_tick;
        logic [7:0] e_da;
        logic [7:0] e_db;
        logic [1:0] e_addr;
    } vec_t;

    vec_t       tbl[25];
    logic [7:0] cpx[4];

    task automatic frame_ab(input int npix);
        for (int k = 0; k < npix; k++) step_ab(1'b0, 1'b0, 1'b1, 8'($urandom));
    endtask

    initial begin
        // Rows 0-1 and 23-24 are pixels while idle; row 2 starts the frame.
        for (int i = 0; i < 25; i++) begin
            tbl[i].fs = (i == 2);
            tbl[i].de = (i != 2);
            tbl[i].px = 8'hFF;
            if (i >= 3 && i <= 22) tbl[i].px = (((i - 3) % 2) == 0) ? 8'hFF : 8'h00;
            tbl[i].e_we = 1'b0; tbl[i].e_tick = 1'b0;
            tbl[i].e_da = 8'h00; tbl[i].e_db = 8'h00; tbl[i].e_addr = 2'd0;
        end
        tbl[10].e_we = 1'b1; tbl[10].e_da = 8'h55; tbl[10].e_db = 8'hAA; tbl[10].e_addr = 2'd0;
        tbl[18].e_we = 1'b1; tbl[18].e_da = 8'h55; tbl[18].e_db = 8'hAA; tbl[18].e_addr = 2'd1;
        tbl[22].e_we = 1'b1; tbl[22].e_da = 8'h05; tbl[22].e_db = 8'hA0; tbl[22].e_addr = 2'd2;
        tbl[22].e_tick = 1'b1;
        cpx[0] = 8'h1F; cpx[1] = 8'hE0; cpx[2] = 8'h70; cpx[3] = 8'h80;

        reset_ab = 1'b1; fs_ab = 1'b0; de_ab = 1'b0; px_ab = 8'h00;

        // 4-bit pixels, two per word, with random idle gaps.
        step_c(1'b1, 1'b0, 1'b0, 8'h00);
        step_c(1'b1, 1'b0, 1'b0, 8'h00);
        chk("c_reset_we",   32'(we_c),   32'd0);
        chk("c_reset_data", 32'(data_c), 32'd0);
        chk("c_reset_tick", 32'(tick_c), 32'd0);
        step_c(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) step_c(1'b0, 1'b0, 1'b0, 8'h00);
            step_c(1'b0, 1'b0, 1'b1, cpx[k]);
        end
        repeat (3) step_c(1'b0, 1'b0, 1'b1, 8'hFF);
        chk("c_write_count", 32'(c_data.size()), 32'd2);
        if (c_data.size() == 2) begin
            chk("c_word0",  32'(c_data[0]),    32'hE1);
            chk("c_addr0",  32'(c_addr[0]),    32'd0);
            chk("c_tick0",  32'(c_tick_we[0]), 32'd0);
            chk("c_word1",  32'(c_data[1]),    32'h87);
            chk("c_addr1",  32'(c_addr[1]),    32'd1);
            chk("c_tick1",  32'(c_tick_we[1]), 32'd1);
        end
        chk("c_tick_count", 32'(c_ticks), 32'd1);
        chk("c_err_count",  32'(c_errs),  32'd0);

        // Reset state, then the alternating-pixel frame from the table.
        step_ab(1'b1, 1'b0, 1'b0, 8'h00);
        step_ab(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 25; i++) begin
            step_ab(1'b0, tbl[i].fs, tbl[i].de, tbl[i].px);
            chk("tbl_we",   32'(we_a),   32'(tbl[i].e_we));
            chk("tbl_tick", 32'(tick_a), 32'(tbl[i].e_tick));
            chk("tbl_err",  32'(err_a),  32'd0);
            if (tbl[i].e_we) begin
                chk("tbl_data_lsb", 32'(data_a), 32'(tbl[i].e_da));
                chk("tbl_data_msb", 32'(data_b), 32'(tbl[i].e_db));
                chk("tbl_addr",     32'(addr_a), 32'(tbl[i].e_addr));
            end
        end

        // Early abort after 11 pixels with a coincident pixel, then a full frame.
        log_addr.delete(); err_seen = 0; tick_seen = 0;
        step_ab(1'b0, 1'b1, 1'b0, 8'h00);
        frame_ab(11);
        step_ab(1'b0, 1'b1, 1'b1, 8'($urandom));
        frame_ab(19);
        repeat (2) step_ab(1'b0, 1'b0, 1'b1, 8'hFF);
        chk("abort_writes", 32'(log_addr.size()), 32'd4);
        if (log_addr.size() == 4) begin
            chk("abort_addr0", 32'(log_addr[0]), 32'd0);
            chk("abort_addr1", 32'(log_addr[1]), 32'd0);
            chk("abort_addr2", 32'(log_addr[2]), 32'd1);
            chk("abort_addr3", 32'(log_addr[3]), 32'd2);
        end
        chk("abort_errs",  32'(err_seen),  32'd1);
        chk("abort_ticks", 32'(tick_seen), 32'd1);

        // Reset after 5 pixels, then a fresh frame from address 0.
        log_addr.delete(); err_seen = 0; tick_seen = 0;
        step_ab(1'b0, 1'b1, 1'b0, 8'h00);
        frame_ab(5);
        step_ab(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_we",   32'(we_a),   32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_tick", 32'(tick_a), 32'd0);
        chk("rst_err",  32'(err_a),  32'd0);
        step_ab(1'b0, 1'b1, 1'b0, 8'h00);
        frame_ab(20);
        chk("rst_writes", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) chk("rst_first_addr", 32'(log_addr[0]), 32'd0);
        chk("rst_errs",  32'(err_seen),  32'd0);
        chk("rst_ticks", 32'(tick_seen), 32'd1);

        // frame_start with a word-completing pixel, then with the final pixel.
        step_ab(1'b0, 1'b1, 1'b0, 8'h00);
        frame_ab(7);
        step_ab(1'b0, 1'b1, 1'b1, 8'hFF);
        frame_ab(19);
        step_ab(1'b0, 1'b1, 1'b1, 8'h00);
        frame_ab(22);

        // Random traffic with occasional frame starts and resets.
        for (int i = 0; i < 3000; i++) begin
            step_ab($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) < 7, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL timeout: bench still running at time limit, required to have finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit reached");
    end

endmodule
